fifo_512_40bit_stream_rd: RTL and testbench

- Downstream read stage for the 512x40 FIFO.
- Converts the FIFO's raw re/empty interface into a valid/ready stream, absorbing the FIFO's 1-cycle registered read latency with a 2-entry output buffer.
- Sustains 1 beat/cycle with no bubbles under continuous m_ready.
- Sits between the FIFO read port and any stream consumer.

---
 rtl/fifo_512_40bit_stream_rd.sv | 115 +++++++++++
 tb/tb_fifo_512_40bit_stream_rd.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_512_40bit_stream_rd.sv
// ============================================================================
// fifo_512_40bit_stream_rd : FIFO read port to valid/ready stream, 2-entry
// buffer. Optional stats: FIFO_STREAM_RD_STATS_EN.  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_512_40bit_stream_rd #(
   parameter int DW = 40
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          fifo_empty,
   output logic          fifo_re,
   input  logic [DW-1:0] fifo_dout,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic          busy
`ifdef FIFO_STREAM_RD_STATS_EN
   ,
   output logic [31:0]   beat_cnt,
   output logic [31:0]   stall_cnt
`endif
);

   logic          head_v;
   logic [DW-1:0] head_d;
   logic          skid_v;
   logic [DW-1:0] skid_d;
   logic          inflight;

   logic [1:0]    buf_cnt;
   logic [1:0]    occ;
   logic [1:0]    occ_after;
   logic          pop;
   logic          cap;

   // Credit check: buffered + outstanding words after this cycle's pop must
   // leave room for the word a new read would return.
   always_comb begin
      buf_cnt   = {1'b0, head_v} + {1'b0, skid_v};
      occ       = buf_cnt + {1'b0, inflight};
      pop       = head_v & m_ready;
      occ_after = occ - {1'b0, pop};
      cap       = inflight;
      fifo_re   = en & ~clr & ~fifo_empty & (occ_after < 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_v   <= 1'b0;
         head_d   <= '0;
         skid_v   <= 1'b0;
         skid_d   <= '0;
         inflight <= 1'b0;
      end else if (clr) begin
         head_v   <= 1'b0;
         skid_v   <= 1'b0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_re;
         if (pop) begin
            if (skid_v) begin
               head_d <= skid_d;
               if (cap) begin
                  skid_d <= fifo_dout;
               end else begin
                  skid_v <= 1'b0;
               end
            end else if (cap) begin
               head_d <= fifo_dout;
            end else begin
               head_v <= 1'b0;
            end
         end else if (cap) begin
            if (!head_v) begin
               head_v <= 1'b1;
               head_d <= fifo_dout;
            end else begin
               skid_v <= 1'b1;
               skid_d <= fifo_dout;
            end
         end
      end
   end

   assign m_valid = head_v;
   assign m_data  = head_d;
   assign busy    = head_v | skid_v | inflight;

`ifdef FIFO_STREAM_RD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else if (clr) begin
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop) begin
            beat_cnt <= beat_cnt + 32'd1;
         end
         if (head_v & ~m_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_512_40bit_stream_rd.sv
// ============================================================================
// tb_fifo_512_40bit_stream_rd : randomized self-checking bench with a queue
// model of the upstream FIFO and of outstanding words.  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_512_40bit_stream_rd;

   localparam int DW = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          en;
   logic          fifo_empty;
   logic          fifo_re;
   logic [DW-1:0] fifo_dout;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic          busy;
`ifdef FIFO_STREAM_RD_STATS_EN
   logic [31:0]   beat_cnt;
   logic [31:0]   stall_cnt;
`endif

   fifo_512_40bit_stream_rd #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .fifo_dout  (fifo_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .busy       (busy)
`ifdef FIFO_STREAM_RD_STATS_EN
      ,
      .beat_cnt   (beat_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] mem[$];
   logic [DW-1:0] exp_q[$];
   int            infl = 0;
   int            cyc = 0;
   int            pop_cnt = 0;
   int            re_cnt = 0;
   int            last_pop_cyc = 0;
   logic [DW-1:0] last_pop_data = '0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_stall = 1'b0;
   logic [31:0]   mb = '0;
   logic [31:0]   ms = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // Outstanding words (read from the FIFO, not yet accepted) in order;
   // infl marks whether the youngest one is still on its way back.
   task automatic monitor();
      int   nbuf;
      logic pop;
      logic re_exp;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         infl       = 0;
         prev_stall = 1'b0;
         mb         = '0;
         ms         = '0;
         return;
      end
      nbuf   = exp_q.size() - infl;
      pop    = m_valid & m_ready;
      re_exp = en && !clr && !fifo_empty && ((exp_q.size() - (pop ? 1 : 0)) < 2);
      check("busy", busy, 64'(exp_q.size() != 0));
      check("m_valid", m_valid, 64'(nbuf > 0));
      if (m_valid && nbuf > 0) check("m_data", m_data, exp_q[0]);
      if (prev_stall) check("hold", m_data, prev_data);
      check("fifo_re", fifo_re, re_exp);
      check("re_guard", fifo_re & fifo_empty, 0);
`ifdef FIFO_STREAM_RD_STATS_EN
      check("beat_cnt", beat_cnt, mb);
      check("stall_cnt", stall_cnt, ms);
      if (pop) mb = mb + 32'd1;
      if (m_valid && !m_ready) ms = ms + 32'd1;
      if (clr) begin
         mb = '0;
         ms = '0;
      end
`endif
      if (pop) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         pop_cnt++;
         last_pop_cyc  = cyc;
         last_pop_data = m_data;
      end
      if (fifo_re) re_cnt++;
      if (clr) begin
         exp_q.delete();
         infl       = 0;
         prev_stall = 1'b0;
      end else begin
         infl = fifo_re ? 1 : 0;
         if (fifo_re && mem.size() > 0) exp_q.push_back(mem[0]);
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
      end
   endtask

   // Upstream FIFO: registered read data and registered empty flag.
   task automatic fifo_model();
      if (!rst_n) begin
         mem.delete();
         fifo_empty <= 1'b1;
         fifo_dout  <= '0;
      end else begin
         if (fifo_re && mem.size() > 0) fifo_dout <= mem.pop_front();
         fifo_empty <= (mem.size() == 0);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         monitor();
         @(posedge clk);
         fifo_model();
         #1;
      end
   endtask

   task automatic push_seq(input int base, input int n);
      for (int i = 0; i < n; i++) mem.push_back(DW'(base + i));
   endtask

   task automatic wait_pops(input int p0, input int target, input int bound);
      for (int i = 0; i < bound && (pop_cnt - p0) < target; i++) step(1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] watchdog timeout, got no completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int r0;
      int en_cyc;
      int first_cyc;
      logic [DW-1:0] first_data;

      rst_n      = 1'b0;
      clr        = 1'b0;
      en         = 1'b1;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      @(posedge clk);
      #1;
      step(2);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_fifo_re", fifo_re, 0);
      rst_n = 1'b1;
      en    = 1'b0;
      step(2);

      // Streaming, no backpressure
      p0 = pop_cnt;
      push_seq(1, 8);
      step(2);
      en      = 1'b1;
      m_ready = 1'b1;
      en_cyc  = cyc + 1;
      wait_pops(p0, 1, 20);
      first_cyc = last_pop_cyc;
      wait_pops(p0, 8, 30);
      check("stream_lat", first_cyc - en_cyc, 2);
      check("stream_burst", last_pop_cyc - first_cyc, 7);
      check("stream_cnt", pop_cnt - p0, 8);
      check("stream_last", last_pop_data, 8);
      step(1);
      check("stream_busy", busy, 0);

      // Backpressure
      en      = 1'b0;
      m_ready = 1'b0;
      p0 = pop_cnt;
      r0 = re_cnt;
      push_seq(10, 4);
      step(2);
      en = 1'b1;
      step(10);
      check("bp_re", re_cnt - r0, 2);
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 10);
      check("bp_nopop", pop_cnt - p0, 0);
      m_ready = 1'b1;
      wait_pops(p0, 1, 10);
      first_cyc = last_pop_cyc;
      wait_pops(p0, 4, 20);
      check("bp_burst", last_pop_cyc - first_cyc, 3);
      check("bp_last", last_pop_data, 13);
      step(2);

      // Empty guard
      p0 = pop_cnt;
      r0 = re_cnt;
      step(20);
      check("empty_re", re_cnt - r0, 0);
      mem.push_back(DW'(77));
      wait_pops(p0, 1, 20);
      step(3);
      check("empty_re1", re_cnt - r0, 1);
      check("empty_pops", pop_cnt - p0, 1);
      check("empty_data", last_pop_data, 77);

      // Random m_ready over a full FIFO load
      p0 = pop_cnt;
      r0 = re_cnt;
      push_seq(0, 512);
      for (int i = 0; i < 6000 && (pop_cnt - p0) < 512; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         step(1);
      end
      m_ready = 1'b1;
      step(3);
      check("rand_pops", pop_cnt - p0, 512);
      check("rand_re", re_cnt - r0, 512);
      check("rand_last", last_pop_data, 511);

      // Flush with a buffered word and one in flight
      en      = 1'b0;
      m_ready = 1'b0;
      push_seq(100, 4);
      step(2);
      en = 1'b1;
      step(2);
      check("clr_pre_valid", m_valid, 1);
      check("clr_pre_busy", busy, 1);
      clr = 1'b1;
      step(1);
      check("clr_valid", m_valid, 0);
      check("clr_busy", busy, 0);
      clr     = 1'b0;
      m_ready = 1'b1;
      p0 = pop_cnt;
      wait_pops(p0, 1, 20);
      first_data = last_pop_data;
      check("clr_next", first_data, 102);
      wait_pops(p0, 2, 20);
      check("clr_last", last_pop_data, 103);
      step(2);

      // en dropped mid-stream
      en      = 1'b0;
      m_ready = 1'b1;
      p0 = pop_cnt;
      r0 = re_cnt;
      push_seq(200, 10);
      step(2);
      en = 1'b1;
      step(4);
      en = 1'b0;
      step(1);
      check("en_re_drop", fifo_re, 0);
      step(2);
      check("en_pops", pop_cnt - p0, 4);
      check("en_re", re_cnt - r0, 4);
      check("en_last", last_pop_data, 203);
      check("en_valid", m_valid, 0);
      check("en_busy", busy, 0);
      en = 1'b1;
      wait_pops(p0, 10, 30);
      check("en_resume_pops", pop_cnt - p0, 10);
      check("en_resume_last", last_pop_data, 209);
      step(2);

      // Asynchronous reset mid-transfer
      push_seq(300, 6);
      step(4);
      check("ar_pre_valid", m_valid, 1);
      #2;
      rst_n = 1'b0;
      mem.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
      #1;
      check("ar_valid", m_valid, 0);
      check("ar_busy", busy, 0);
      check("ar_data", m_data, 0);
      step(1);
      rst_n = 1'b1;
      step(3);
      check("ar_post_valid", m_valid, 0);
      check("ar_post_busy", busy, 0);
      check("ar_post_re", fifo_re, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
